// File: rtl/pe_routine_sequencer.sv
// pe_routine_sequencer
//   Initiator side of the PE dataflow-controller start/stop protocol.
//   For each output window it pulses Start_Routine for one cycle, keeps the
//   PE array accumulating for Ker_Len cycles, pulses Stop_Routine for one
//   cycle, waits Drain cycles for the PE output register, then pulses
//   Window_Valid. After the last window it pulses Done and returns to idle.
//   Window period = Ker_Len + Drain + 3 cycles; Go -> first Start = 1 cycle.
//
// Ports
//   PERS_Clk, PERS_Reset      clock, asynchronous active-high reset
//   PERS_Go                   start-of-layer request (sampled only when idle)
//   PERS_Abort                abandon the current layer (ignored when idle)
//   PERS_Ker_Len              accumulate cycles per window (latched on Go)
//   PERS_Num_Windows          windows per layer (latched on Go)
//   PERS_Drain                cycles between Stop and Window_Valid (latched on Go)
//   PERS_Start_Routine        1-cycle pulse to the PE dataflow controller
//   PERS_Stop_Routine         1-cycle pulse to the PE dataflow controller
//   PERS_Window_Valid         1-cycle pulse: PE output holds window Window_Idx
//   PERS_Window_Idx           0-based index of the current window
//   PERS_Busy                 high in every state except idle
//   PERS_Done                 1-cycle pulse: all windows complete
//   PERS_Cfg_Err              1-cycle pulse: Go seen with a zero Ker_Len or Num_Windows
module pe_routine_sequencer #(
    parameter int CNT_W = 8,
    parameter int IDX_W = 10
) (
    input  logic             PERS_Clk,
    input  logic             PERS_Reset,
    input  logic             PERS_Go,
    input  logic             PERS_Abort,
    input  logic [CNT_W-1:0] PERS_Ker_Len,
    input  logic [IDX_W-1:0] PERS_Num_Windows,
    input  logic [CNT_W-1:0] PERS_Drain,
    output logic             PERS_Start_Routine,
    output logic             PERS_Stop_Routine,
    output logic             PERS_Window_Valid,
    output logic [IDX_W-1:0] PERS_Window_Idx,
    output logic             PERS_Busy,
    output logic             PERS_Done,
    output logic             PERS_Cfg_Err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_WOUT  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ABORT = 3'd7;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] ker_len_q;
    logic [CNT_W-1:0] drain_q;
    logic [IDX_W-1:0] num_win_q;
    logic [IDX_W-1:0] win_idx;
    logic             cfg_err_q;

    always_ff @(posedge PERS_Clk or posedge PERS_Reset) begin
        if (PERS_Reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ker_len_q <= '0;
            drain_q   <= '0;
            num_win_q <= '0;
            win_idx   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Go has priority over Abort here; Abort is meaningless when idle.
                    if (PERS_Go) begin
                        if (PERS_Ker_Len != '0 && PERS_Num_Windows != '0) begin
                            ker_len_q <= PERS_Ker_Len;
                            drain_q   <= PERS_Drain;
                            num_win_q <= PERS_Num_Windows;
                            win_idx   <= '0;
                            state     <= S_START;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    cnt   <= '0;
                    state <= PERS_Abort ? S_ABORT : S_RUN;
                end
                S_RUN: begin
                    // The PE controller has been opened, so an abort must close it with a Stop.
                    if (PERS_Abort) begin
                        state <= S_ABORT;
                    end else if (cnt == ker_len_q - CNT_ONE) begin
                        state <= S_STOP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (PERS_Abort) begin
                        state <= S_IDLE;
                    end else if (drain_q == '0) begin
                        state <= S_WOUT;
                    end else begin
                        cnt   <= '0;
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (PERS_Abort) begin
                        state <= S_IDLE;
                    end else if (cnt == drain_q - CNT_ONE) begin
                        state <= S_WOUT;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_WOUT: begin
                    // Window index advances only on a normal exit towards the next window.
                    if (PERS_Abort) begin
                        state <= S_IDLE;
                    end else if (win_idx == num_win_q - IDX_ONE) begin
                        state <= S_DONE;
                    end else begin
                        win_idx <= win_idx + IDX_ONE;
                        state   <= S_START;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ABORT: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Moore decode: outputs follow the registered state, so async reset clears them at once.
    assign PERS_Start_Routine = (state == S_START);
    assign PERS_Stop_Routine  = (state == S_STOP) || (state == S_ABORT);
    assign PERS_Window_Valid  = (state == S_WOUT);
    assign PERS_Done          = (state == S_DONE);
    assign PERS_Busy          = (state != S_IDLE);
    assign PERS_Cfg_Err       = cfg_err_q;
    assign PERS_Window_Idx    = win_idx;

endmodule

// File: tb/tb_pe_routine_sequencer.sv
module tb_pe_routine_sequencer;

    localparam int CNT_W = 8;
    localparam int IDX_W = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             go;
    logic             abort;
    logic [CNT_W-1:0] k;
    logic [IDX_W-1:0] n;
    logic [CNT_W-1:0] d;
    logic             start_r, stop_r, wv, busy, done, cfg_err;
    logic [IDX_W-1:0] widx;

    pe_routine_sequencer #(.CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
        .PERS_Clk          (clk),
        .PERS_Reset        (rst),
        .PERS_Go           (go),
        .PERS_Abort        (abort),
        .PERS_Ker_Len      (k),
        .PERS_Num_Windows  (n),
        .PERS_Drain        (d),
        .PERS_Start_Routine(start_r),
        .PERS_Stop_Routine (stop_r),
        .PERS_Window_Valid (wv),
        .PERS_Window_Idx   (widx),
        .PERS_Busy         (busy),
        .PERS_Done         (done),
        .PERS_Cfg_Err      (cfg_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Output vector layout: {start, stop, window_valid, busy, done, cfg_err, idx[9:0]}
    function automatic logic [15:0] pack(input bit s, input bit p, input bit v, input bit b,
                                         input bit dn, input bit ce, input int idx);
        logic [9:0] i10;
        i10 = 10'(idx);
        return {s, p, v, b, dn, ce, i10};
    endfunction

    function automatic logic [15:0] dut_out();
        return {start_r, stop_r, wv, busy, done, cfg_err, widx};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h (s,p,v,b,dn,ce,idx)", name, cyc, act, exp);
        end
    endtask

    // Reference model: the layer is a timeline of windows of period K+D+3 that
    // starts one cycle after an accepted Go; r is the offset into that timeline.
    int m_active, m_r, m_k, m_n, m_d, m_abstop, m_idx, m_cfgerr;

    task automatic model_reset();
        m_active = 0; m_r = 0; m_k = 0; m_n = 0; m_d = 0;
        m_abstop = 0; m_idx = 0; m_cfgerr = 0;
    endtask

    function automatic logic [15:0] model_out();
        int p, w, o;
        if (m_abstop != 0) return pack(0, 1, 0, 1, 0, 0, m_idx);
        if (m_active != 0) begin
            p = m_k + m_d + 3;
            if (m_r == 1 + m_n * p) return pack(0, 0, 0, 1, 1, 0, m_n - 1);
            w = (m_r - 1) / p;
            o = (m_r - 1) % p;
            return pack(o == 0, o == m_k + 1, o == m_k + 2 + m_d, 1, 0, 0, w);
        end
        return pack(0, 0, 0, 0, 0, m_cfgerr != 0, m_idx);
    endfunction

    task automatic model_update(input bit g, input bit a, input int kk, input int nn, input int dd);
        int p, o;
        logic [15:0] cur;
        cur = model_out();
        if (m_abstop != 0) begin
            m_abstop = 0;
            m_cfgerr = 0;
        end else if (m_active != 0) begin
            m_cfgerr = 0;
            m_idx = int'(cur[9:0]);
            p = m_k + m_d + 3;
            o = (m_r - 1) % p;
            if (a) begin
                if (m_r < 1 + m_n * p && o <= m_k) m_abstop = 1;
                m_active = 0;
            end else begin
                m_r++;
                if (m_r > 1 + m_n * p) m_active = 0;
            end
        end else begin
            m_cfgerr = 0;
            if (g) begin
                if (kk != 0 && nn != 0) begin
                    m_k = kk; m_n = nn; m_d = dd;
                    m_active = 1; m_r = 1; m_idx = 0;
                end else begin
                    m_cfgerr = 1;
                end
            end
        end
    endtask

    // One clock cycle: drive inputs just after the edge, sample mid-cycle,
    // compare against the model, then advance the model with this cycle's inputs.
    task automatic step(input bit g, input bit a, input int kk, input int nn, input int dd,
                        output logic [15:0] got);
        @(posedge clk);
        #1;
        go = g; abort = a; k = 8'(kk); n = 10'(nn); d = 8'(dd);
        @(negedge clk);
        got = dut_out();
        check("model", got, model_out());
        model_update(g, a, kk, nn, dd);
        cyc++;
    endtask

    typedef struct {
        bit          go;
        bit          ab;
        int          kk;
        int          nn;
        int          dd;
        logic [15:0] exp;
    } vec_t;

    vec_t        vecs[12];
    logic [15:0] got;

    initial begin
        // K=1,N=1,D=0 single-window layer, then two zero-config Go attempts.
        vecs[0]  = '{1, 0, 1, 1, 0, pack(0, 0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{0, 0, 1, 1, 0, pack(1, 0, 0, 1, 0, 0, 0)};
        vecs[2]  = '{0, 0, 1, 1, 0, pack(0, 0, 0, 1, 0, 0, 0)};
        vecs[3]  = '{0, 0, 1, 1, 0, pack(0, 1, 0, 1, 0, 0, 0)};
        vecs[4]  = '{0, 0, 1, 1, 0, pack(0, 0, 1, 1, 0, 0, 0)};
        vecs[5]  = '{0, 0, 1, 1, 0, pack(0, 0, 0, 1, 1, 0, 0)};
        vecs[6]  = '{0, 0, 1, 1, 0, pack(0, 0, 0, 0, 0, 0, 0)};
        vecs[7]  = '{1, 0, 0, 4, 0, pack(0, 0, 0, 0, 0, 0, 0)};
        vecs[8]  = '{0, 0, 0, 4, 0, pack(0, 0, 0, 0, 0, 1, 0)};
        vecs[9]  = '{1, 0, 2, 0, 1, pack(0, 0, 0, 0, 0, 0, 0)};
        vecs[10] = '{0, 0, 2, 0, 1, pack(0, 0, 0, 0, 0, 1, 0)};
        vecs[11] = '{0, 0, 2, 0, 1, pack(0, 0, 0, 0, 0, 0, 0)};

        rst = 1'b1; go = 1'b0; abort = 1'b0; k = '0; n = '0; d = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", dut_out(), 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].go, vecs[i].ab, vecs[i].kk, vecs[i].nn, vecs[i].dd, got);
            check("vec", got, vecs[i].exp);
        end

        // K=3,N=2,D=1: Start c1,c8; Stop c5,c12; Valid c7,c14; Done c15; Busy c1..c15.
        for (int c = 0; c <= 16; c++) begin
            step(c == 0, 0, 3, 2, 1, got);
            check("k3n2d1", got, pack(c == 1 || c == 8, c == 5 || c == 12, c == 7 || c == 14,
                                      c >= 1 && c <= 15, c == 15, 0, (c >= 8) ? 1 : 0));
        end

        // K=5,N=3,D=2 (period 10): abort in RUN of window 1 at c13.
        for (int c = 0; c <= 20; c++) begin
            step(c == 0, c == 13, 5, 3, 2, got);
            if (c == 11) check("abort_w1_start", got, pack(1, 0, 0, 1, 0, 0, 1));
            if (c == 14) check("abort_stop", got, pack(0, 1, 0, 1, 0, 0, 1));
            if (c >= 15) check("abort_idle", got, pack(0, 0, 0, 0, 0, 0, 1));
        end

        // Go during RUN is ignored; Go+Abort in IDLE starts a new layer.
        for (int c = 0; c <= 13; c++) begin
            if (c == 3)      step(1, 0, 7, 5, 4, got);
            else if (c == 7) step(1, 1, 1, 1, 0, got);
            else             step(c == 0, 0, (c >= 8) ? 1 : 2, 1, 0, got);
            if (c == 4)  check("ignored_go_stop", got, pack(0, 1, 0, 1, 0, 0, 0));
            if (c == 6)  check("ignored_go_done", got, pack(0, 0, 0, 1, 1, 0, 0));
            if (c == 8)  check("go_beats_abort", got, pack(1, 0, 0, 1, 0, 0, 0));
            if (c == 12) check("second_done", got, pack(0, 0, 0, 1, 1, 0, 0));
        end

        // Asynchronous reset in the middle of RUN of window 0.
        for (int c = 0; c <= 3; c++) step(c == 0, 0, 4, 2, 1, got);
        @(posedge clk);
        #1 go = 1'b0;
        #2 rst = 1'b1;
        #1 check("async_reset", dut_out(), 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c <= 10; c++) begin
            step(c == 0, 0, 1, 2, 0, got);
            if (c == 4) check("post_reset_w0", got, pack(0, 0, 1, 1, 0, 0, 0));
            if (c == 8) check("post_reset_w1", got, pack(0, 0, 1, 1, 0, 0, 1));
        end

        // Maximum counter values: K=255, D=255, one window.
        for (int c = 0; c <= 520; c++) begin
            step(c == 0, 0, 255, 1, 255, got);
            if (c == 257) check("max_stop", got, pack(0, 1, 0, 1, 0, 0, 0));
            if (c == 513) check("max_valid", got, pack(0, 0, 1, 1, 0, 0, 0));
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 5) == 0, $urandom_range(0, 29) == 0,
                 int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 3)), got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
